memory_bus_arbiter: RTL and testbench

//  Shares the single memory handshake (EN, R_W, MFC) between the instruction-fetch FSM and the execute FSMs.

---
 rtl/memory_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Shares one memory handshake (EN, R_W, MFC) between the fetch and execute FSMs. One requester
//   owns the bus at a time, ties are broken round-robin, MFC is routed back to the owner only, and
//   accesses that hang without MFC are aborted after TIMEOUT_CYCLES cycles (0 disables the abort).
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   if_req/if_rw          : fetch request (held until if_mfc consumed) and direction, 1=read
//   ex_req/ex_rw          : execute request and direction
//   MFC                   : memory function complete
//   EN, R_W               : memory enable and direction (owner's latched rw)
//   if_gnt/ex_gnt         : bus ownership, also selects whose MAR/MDR controls drive the bus
//   if_mfc/ex_mfc         : one-cycle completion pulse to the owner
//   timeout_err           : one-cycle pulse when an access is aborted on timeout
//   busy                  : high whenever the arbiter is not idle
module memory_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic if_req,
  input  logic if_rw,
  input  logic ex_req,
  input  logic ex_rw,
  input  logic MFC,
  output logic EN,
  output logic R_W,
  output logic if_gnt,
  output logic ex_gnt,
  output logic if_mfc,
  output logic ex_mfc,
  output logic timeout_err,
  output logic busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StAccess, StRelease} state_e;

  localparam logic OwnerIf = 1'b0;
  localparam logic OwnerEx = 1'b1;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TimeoutOn  = (TIMEOUT_CYCLES != 0);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             rw_q, rw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             owner_req;
  logic             mfc_hit, err_hit;

  logic en_d, rw_out_d, if_gnt_d, ex_gnt_d, if_mfc_d, ex_mfc_d, err_d, busy_d;

  assign owner_req = (owner_q == OwnerEx) ? ex_req : if_req;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    mfc_hit = 1'b0;
    err_hit = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req || ex_req) begin
          // On a tie the requester that did not own the bus last time wins.
          if (if_req && ex_req) owner_d = ~last_q;
          else                  owner_d = ex_req ? OwnerEx : OwnerIf;
          last_d  = owner_d;
          rw_d    = (owner_d == OwnerEx) ? ex_rw : if_rw;
          state_d = StGrant;
        end
      end
      StGrant: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        // A withdrawn request aborts silently; MFC beats a coincident timeout.
        if (!owner_req) begin
          state_d = StIdle;
        end else if (MFC) begin
          mfc_hit = 1'b1;
          state_d = StRelease;
        end else if (TimeoutOn && (cnt_inc == TimeoutVal)) begin
          err_hit = 1'b1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRelease: begin
        if (!owner_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the next state.
    busy_d   = (state_d != StIdle);
    en_d     = (state_d == StAccess);
    rw_out_d = busy_d & rw_d;
    if_gnt_d = busy_d & (owner_d == OwnerIf);
    ex_gnt_d = busy_d & (owner_d == OwnerEx);
    if_mfc_d = mfc_hit & (owner_d == OwnerIf);
    ex_mfc_d = mfc_hit & (owner_d == OwnerEx);
    err_d    = err_hit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnerIf;
      last_q      <= OwnerEx;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      EN          <= 1'b0;
      R_W         <= 1'b0;
      if_gnt      <= 1'b0;
      ex_gnt      <= 1'b0;
      if_mfc      <= 1'b0;
      ex_mfc      <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      rw_q        <= rw_d;
      cnt_q       <= cnt_d;
      EN          <= en_d;
      R_W         <= rw_out_d;
      if_gnt      <= if_gnt_d;
      ex_gnt      <= ex_gnt_d;
      if_mfc      <= if_mfc_d;
      ex_mfc      <= ex_mfc_d;
      timeout_err <= err_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Testbench for memory_bus_arbiter: directed scenarios with literal expectations plus a randomized
// run, all cross-checked every cycle against a transaction-level model of the arbiter.
module tb_memory_bus_arbiter;

  localparam int unsigned TO = 15;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic if_req = 1'b0, if_rw = 1'b0, ex_req = 1'b0, ex_rw = 1'b0, MFC = 1'b0;
  logic EN, R_W, if_gnt, ex_gnt, if_mfc, ex_mfc, timeout_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;

  memory_bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_rw      (if_rw),
    .ex_req     (ex_req),
    .ex_rw      (ex_rw),
    .MFC        (MFC),
    .EN         (EN),
    .R_W        (R_W),
    .if_gnt     (if_gnt),
    .ex_gnt     (ex_gnt),
    .if_mfc     (if_mfc),
    .ex_mfc     (ex_mfc),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: an owner holds the bus from grant until its request drops;
  // m_age counts edges since the grant (0 = address-load cycle, k = k-th access cycle).
  bit m_busy, m_owner, m_last, m_rw, m_done, m_mfc_p, m_err_p;
  int m_age;
  logic m_oreq;
  assign m_oreq = m_owner ? ex_req : if_req;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; m_owner <= 0; m_last <= 1; m_rw <= 0; m_done <= 0; m_age <= 0;
      m_mfc_p <= 0; m_err_p <= 0;
    end else begin
      m_mfc_p <= 0;
      m_err_p <= 0;
      if (!m_busy) begin
        if (if_req || ex_req) begin
          m_busy  <= 1;
          m_age   <= 0;
          m_done  <= 0;
          m_owner <= (if_req && ex_req) ? !m_last : ex_req;
          m_last  <= (if_req && ex_req) ? !m_last : ex_req;
          m_rw    <= ((if_req && ex_req) ? !m_last : ex_req) ? ex_rw : if_rw;
        end
      end else if (m_age == 0) begin
        m_age <= 1;
      end else if (!m_done) begin
        if (!m_oreq) m_busy <= 0;
        else if (MFC) begin m_done <= 1; m_mfc_p <= 1; end
        else if (TO != 0 && m_age == TO) begin m_done <= 1; m_err_p <= 1; end
        else m_age <= m_age + 1;
      end else if (!m_oreq) begin
        m_busy <= 0;
      end
    end
  end

  logic e_en, e_rw, e_if_gnt, e_ex_gnt, e_if_mfc, e_ex_mfc;
  assign e_en     = m_busy && m_age >= 1 && !m_done;
  assign e_rw     = m_busy && m_rw;
  assign e_if_gnt = m_busy && !m_owner;
  assign e_ex_gnt = m_busy && m_owner;
  assign e_if_mfc = m_mfc_p && !m_owner;
  assign e_ex_mfc = m_mfc_p && m_owner;

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_EN", EN, e_en);
      check("cyc_R_W", R_W, e_rw);
      check("cyc_if_gnt", if_gnt, e_if_gnt);
      check("cyc_ex_gnt", ex_gnt, e_ex_gnt);
      check("cyc_if_mfc", if_mfc, e_if_mfc);
      check("cyc_ex_mfc", ex_mfc, e_ex_mfc);
      check("cyc_timeout_err", timeout_err, m_err_p);
      check("cyc_busy", busy, m_busy);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t: got 0 expected 1", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clock);
    if_req = 0; ex_req = 0; if_rw = 0; ex_rw = 0; MFC = 0;
    reset = 0;
    @(negedge clock);
    reset = 1;
  endtask

  task automatic wait_en(input string name);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (EN) begin ok = 1; break; end
      @(negedge clock);
    end
    if (!ok) check(name, EN, 1);
  endtask

  initial begin
    int seq[$];
    bit pi, pe;
    int en_n, err_n, mfc_n, quiet;

    repeat (2) @(negedge clock);
    check("rst_EN", EN, 0);
    check("rst_gnt", {if_gnt, ex_gnt}, 0);
    check("rst_busy", busy, 0);
    reset = 1;
    chk_en = 1;

    // 1: single fetch read, MFC sampled at the 3rd access edge
    do_reset();
    if_req = 1; if_rw = 1;
    @(negedge clock);
    check("t1_gnt_edge1", if_gnt, 1);
    check("t1_en_edge1", EN, 0);
    @(negedge clock);
    check("t1_en_edge2", EN, 1);
    check("t1_rw_edge2", R_W, 1);
    check("t1_model_en", e_en, 1);
    repeat (2) @(negedge clock);
    check("t1_en_c3", EN, 1);
    MFC = 1;
    @(negedge clock);
    MFC = 0;
    check("t1_mfc", if_mfc, 1);
    check("t1_model_mfc", e_if_mfc, 1);
    check("t1_en_rel", EN, 0);
    check("t1_gnt_rel", if_gnt, 1);
    if_req = 0;
    @(negedge clock);
    check("t1_mfc_once", if_mfc, 0);
    check("t1_idle", busy, 0);
    check("t1_gnt_off", if_gnt, 0);

    // 2: both requesters keep asking; grants must alternate starting with fetch
    do_reset();
    if_req = 1; ex_req = 1;
    pi = 0; pe = 0;
    for (int c = 0; c < 200 && seq.size() < 4; c++) begin
      @(negedge clock);
      if (if_gnt && !pi) seq.push_back(0);
      if (ex_gnt && !pe) seq.push_back(1);
      pi = if_gnt; pe = ex_gnt;
      MFC = EN;
      if_req = !if_mfc;
      ex_req = !ex_mfc;
    end
    check("t2_count", seq.size(), 4);
    foreach (seq[i]) check("t2_order", seq[i], i % 2);
    MFC = 0; if_req = 0; ex_req = 0;
    repeat (3) @(negedge clock);

    // 3: execute write that never completes
    do_reset();
    ex_req = 1; ex_rw = 0;
    wait_en("t3_en_seen");
    en_n = 0; err_n = 0; mfc_n = 0;
    for (int c = 0; c < 60; c++) begin
      if (EN) en_n++;
      if (ex_mfc) mfc_n++;
      if (timeout_err) begin
        err_n++;
        check("t3_en_at_err", EN, 0);
        break;
      end
      @(negedge clock);
    end
    check("t3_en_cycles", en_n, 15);
    check("t3_err_seen", err_n, 1);
    check("t3_no_mfc", mfc_n, 0);
    @(negedge clock);
    check("t3_err_pulse", timeout_err, 0);
    ex_req = 0;
    @(negedge clock);

    // 4: fetch withdraws mid-access, pending execute takes over
    do_reset();
    if_req = 1;
    wait_en("t4_en_seen");
    if_req = 0; ex_req = 1;
    @(negedge clock);
    check("t4_en", EN, 0);
    check("t4_if_gnt", if_gnt, 0);
    check("t4_if_mfc", if_mfc, 0);
    check("t4_err", timeout_err, 0);
    check("t4_busy", busy, 0);
    @(negedge clock);
    check("t4_ex_gnt", ex_gnt, 1);
    wait_en("t4_ex_en");
    MFC = 1;
    @(negedge clock);
    MFC = 0;
    check("t4_ex_mfc", ex_mfc, 1);
    ex_req = 0;
    @(negedge clock);

    // 5: asynchronous reset between edges, then fetch wins the first tie
    do_reset();
    if_req = 1;
    wait_en("t5_en_seen");
    #2 reset = 0;
    #1;
    check("t5_en_async", EN, 0);
    check("t5_gnt_async", {if_gnt, ex_gnt}, 0);
    check("t5_busy_async", busy, 0);
    ex_req = 1;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("t5_tie_if", if_gnt, 1);
    check("t5_tie_ex", ex_gnt, 0);
    if_req = 0; ex_req = 0;
    repeat (3) @(negedge clock);

    // 6: MFC in idle is ignored; MFC on the timeout edge wins
    do_reset();
    MFC = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("t6_idle_busy", busy, 0);
      check("t6_idle_mfc", {if_mfc, ex_mfc}, 0);
    end
    MFC = 0;
    ex_req = 1; ex_rw = 1;
    wait_en("t6_en_seen");
    repeat (14) @(negedge clock);
    check("t6_en_last", EN, 1);
    MFC = 1;
    @(negedge clock);
    MFC = 0;
    check("t6_mfc", ex_mfc, 1);
    check("t6_no_err", timeout_err, 0);
    check("t6_en_off", EN, 0);
    ex_req = 0;
    @(negedge clock);
    check("t6_err_after", timeout_err, 0);

    // Randomized traffic, checked by the per-cycle model compare
    do_reset();
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (quiet > 0) quiet--;
      else if ($urandom_range(29) == 0) quiet = 20;
      MFC = (quiet == 0) && ($urandom_range(4) == 0);
      if (if_req) begin
        if (if_mfc || (timeout_err && if_gnt) || $urandom_range(49) == 0) if_req = 0;
      end else if ($urandom_range(2) == 0) begin
        if_req = 1; if_rw = 1'($urandom_range(1));
      end
      if (ex_req) begin
        if (ex_mfc || (timeout_err && ex_gnt) || $urandom_range(49) == 0) ex_req = 0;
      end else if ($urandom_range(2) == 0) begin
        ex_req = 1; ex_rw = 1'($urandom_range(1));
      end
    end
    if_req = 0; ex_req = 0; MFC = 0;
    repeat (4) @(negedge clock);
    check("end_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
